dcache_sa: RTL

- Parametrised N-way set-associative data cache. Successor to the direct-mapped single-cycle dcache.
- Adds valid and dirty bits, byte-enable stores, a write-back / write-allocate policy and round-robin replacement.
- Includes a miss state machine that drives a block-wide memory interface with ready/valid handshakes.
- Sits between the core's MEM stage (load/store port) and the next-level memory.

---
 rtl/dcache_sa.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dcache_sa.sv
// dcache_sa: N-way set-associative write-back/write-allocate data cache with round-robin replacement
module dcache_sa #(
  parameter int DATA_WIDTH  = 32,
  parameter int DCACHE_SIZE = 1,
  parameter int WAYS        = 2,
  parameter int BLOCK_SIZE  = 4
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic                             req_valid,
  input  logic                             req_we,
  input  logic [DATA_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [3:0]                       req_be,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             stall,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_we,
  output logic [DATA_WIDTH-1:0]            mem_req_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_wdata,
  input  logic                             mem_resp_valid,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata
);
  localparam int NUM_SETS = (DCACHE_SIZE*1024/4)/(BLOCK_SIZE*WAYS);
  localparam int OFF_W    = $clog2(BLOCK_SIZE);
  localparam int SET_W    = $clog2(NUM_SETS);
  localparam int TAG_W    = DATA_WIDTH - 2 - OFF_W - SET_W;
  localparam int WAY_W    = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int LINE_W   = BLOCK_SIZE*DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, WB, FILL_REQ, FILL_WAIT} state_t;
  state_t state_q, state_d;
  logic [LINE_W-1:0] data_q  [NUM_SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS][WAYS];
  logic [WAYS-1:0]   valid_q [NUM_SETS];
  logic [WAYS-1:0]   dirty_q [NUM_SETS];
  logic [WAY_W-1:0]  rr_q    [NUM_SETS];
  logic [OFF_W-1:0]  off;
  logic [SET_W-1:0]  set;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  vic;
  logic [LINE_W-1:0] hit_line;
  logic              vic_dirty;
  logic              store_hit;
  logic              fill;
  logic              unused_addr;
  assign off         = req_addr[2 +: OFF_W];
  assign set         = req_addr[2+OFF_W +: SET_W];
  assign tag         = req_addr[DATA_WIDTH-1 -: TAG_W];
  assign unused_addr = ^req_addr[1:0];
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic     = WAYS > 1 ? rr_q[set] : '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set][w] && tag_q[set][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[set][w]) vic = WAY_W'(w);
    end
  end
  assign hit_line  = data_q[set][hit_way];
  assign vic_dirty = valid_q[set][vic] && dirty_q[set][vic];
  assign mem_wdata = data_q[set][vic];
  assign store_hit = state_q == IDLE && req_valid && req_we && hit;
  assign fill      = state_q == FILL_WAIT && mem_resp_valid;
  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    rdata         = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    case (state_q)
      IDLE: begin
        rdata   = req_valid && hit ? hit_line[off*DATA_WIDTH +: DATA_WIDTH] : '0;
        stall   = req_valid && !hit;
        state_d = !stall ? IDLE : vic_dirty ? WB : FILL_REQ;
      end
      WB: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {tag_q[set][vic], set, (OFF_W+2)'(0)};
        state_d       = mem_req_ready ? FILL_REQ : WB;
      end
      FILL_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag, set, (OFF_W+2)'(0)};
        state_d       = mem_req_ready ? FILL_WAIT : FILL_REQ;
      end
      default: begin
        stall   = 1'b1;
        state_d = mem_resp_valid ? IDLE : FILL_WAIT;
      end
    endcase
    stall = stall && arst_n;
    rdata = arst_n ? rdata : '0;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      if (store_hit) dirty_q[set][hit_way] <= 1'b1;
      if (state_q == WB && mem_req_ready) dirty_q[set][vic] <= 1'b0;
      if (fill) begin
        valid_q[set][vic] <= 1'b1;
        dirty_q[set][vic] <= 1'b0;
        rr_q[set]         <= WAYS > 1 ? rr_q[set] + 1'b1 : '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[set][vic] <= mem_rdata;
      tag_q[set][vic]  <= tag;
    end else if (store_hit) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (req_be[b]) data_q[set][hit_way][off*DATA_WIDTH + b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end
endmodule
